// File: rtl/program_counter_ras.sv
// Program counter with stall and a circular return-address stack.
// Define PC_RAS_WRAP_EN to let CALL-on-full overwrite the oldest entry.
module program_counter_ras #(
  parameter int ADDR_W    = 16,
  parameter int INC_STEP  = 1,
  parameter int RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [ADDR_W-1:0]              imm,
  input  logic [ADDR_W-1:0]              alu_out,
  input  logic [2:0]                     mux_input,
  output logic [ADDR_W-1:0]              pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT =
    CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [PTR_W-1:0]  top_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              err_nxt;
  logic              wr_en;

  logic op_branch;
  logic op_jreg;
  logic op_call;
  logic op_ret;
  logic op_seq;

  assign seq_pc    = pc_out + ADDR_W'(INC_STEP);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == FULL_CNT);

  // One-hot decode of the next-PC select
  always_comb begin
    op_branch = (mux_input == 3'b110);
    op_jreg   = (mux_input == 3'b111);
    op_call   = (mux_input == 3'b100);
    op_ret    = (mux_input == 3'b101);
    op_seq    = !(op_branch | op_jreg |
                  op_call | op_ret);
  end

  // Next PC, stack pointer, count and fault
  always_comb begin
    pc_nxt  = pc_out;
    top_nxt = top;
    cnt_nxt = ras_count;
    err_nxt = 1'b0;
    wr_en   = 1'b0;
    if (!stall) begin
      unique case (1'b1)
        op_branch: pc_nxt = imm;
        op_jreg:   pc_nxt = alu_out;
        op_call: begin
          pc_nxt = imm;
          if (!ras_full) begin
            wr_en   = 1'b1;
            top_nxt = top + PTR_W'(1);
            cnt_nxt = ras_count + CNT_W'(1);
          end else begin
`ifdef PC_RAS_WRAP_EN
            // oldest slot sits at top+1
            wr_en   = 1'b1;
            top_nxt = top + PTR_W'(1);
`else
            err_nxt = 1'b1;
`endif
          end
        end
        op_ret: begin
          if (!ras_empty) begin
            pc_nxt  = ras_mem[top];
            top_nxt = top - PTR_W'(1);
            cnt_nxt = ras_count - CNT_W'(1);
          end else begin
            pc_nxt  = alu_out;
            err_nxt = 1'b1;
          end
        end
        op_seq:  pc_nxt = seq_pc;
        default: pc_nxt = seq_pc;
      endcase
    end
  end

  // Architectural state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out    <= RESET_VEC;
      top       <= '0;
      ras_count <= '0;
      ras_err   <= 1'b0;
    end else begin
      pc_out    <= pc_nxt;
      top       <= top_nxt;
      ras_count <= cnt_nxt;
      ras_err   <= err_nxt;
    end
  end

  // Stack storage, written at the new top
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      ras_mem[top_nxt] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_program_counter_ras.sv
// Bench for program_counter_ras: queue-based stack model,
// per-cycle compare plus directed literal checks.
module tb_program_counter_ras;

  localparam int AW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic [AW-1:0] imm;
  logic [AW-1:0] alu_out;
  logic [2:0]    mux_input;
  logic [AW-1:0] pc_out;
  logic [2:0]    ras_count;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_q[$];
  logic          m_err;

  always #5 clk = ~clk;

  program_counter_ras #(
    .ADDR_W(AW), .INC_STEP(1),
    .RAS_DEPTH(D), .RESET_VEC('0)
  ) dut (
    .clk(clk), .reset(reset),
    .stall(stall), .imm(imm),
    .alu_out(alu_out),
    .mux_input(mux_input),
    .pc_out(pc_out),
    .ras_count(ras_count),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_err(ras_err)
  );

  // Reference: stack as a queue, newest at the back
  always @(posedge clk) begin
    logic [AW-1:0] ret;
    if (reset) begin
      m_pc = '0;
      m_q.delete();
      m_err = 1'b0;
    end else if (stall) begin
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      case (mux_input)
        3'b110: m_pc = imm;
        3'b111: m_pc = alu_out;
        3'b100: begin
          if (m_q.size() < D) begin
            m_q.push_back(m_pc + 16'd1);
          end else begin
`ifdef PC_RAS_WRAP_EN
            m_q.push_back(m_pc + 16'd1);
            void'(m_q.pop_front());
`else
            m_err = 1'b1;
`endif
          end
          m_pc = imm;
        end
        3'b101: begin
          if (m_q.size() > 0) begin
            ret = m_q.pop_back();
            m_pc = ret;
          end else begin
            m_pc = alu_out;
            m_err = 1'b1;
          end
        end
        default: m_pc = m_pc + 16'd1;
      endcase
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", 32'(pc_out), 32'(m_pc));
      chk("cnt", 32'(ras_count),
          32'(m_q.size()));
      chk("empty", 32'(ras_empty),
          32'(m_q.size() == 0));
      chk("full", 32'(ras_full),
          32'(m_q.size() == D));
      chk("err", 32'(ras_err), 32'(m_err));
    end
  end

  task automatic cyc(input logic r,
                     input logic s,
                     input logic [2:0] m,
                     input logic [AW-1:0] i,
                     input logic [AW-1:0] a);
    reset = r;
    stall = s;
    mux_input = m;
    imm = i;
    alu_out = a;
    @(negedge clk);
  endtask

  initial begin
    // 1: reset then sequential
    cyc(1, 0, 3'b000, 0, 0);
    chk_en = 1'b1;
    chk("t1_rst_pc", 32'(pc_out), 32'h0);
    chk("t1_empty", 32'(ras_empty), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 3'b000, 0, 0);
      chk("t1_seq", 32'(pc_out), 32'(k));
    end
    // 2: call, seq, return
    cyc(0, 0, 3'b110, 16'h0010, 0);
    cyc(0, 0, 3'b100, 16'h0200, 0);
    chk("t2_call", 32'(pc_out), 32'h0200);
    chk("t2_cnt", 32'(ras_count), 32'h1);
    cyc(0, 0, 3'b000, 0, 0);
    chk("t2_seq", 32'(pc_out), 32'h0201);
    cyc(0, 0, 3'b101, 0, 16'h7777);
    chk("t2_ret", 32'(pc_out), 32'h0011);
    chk("t2_empty", 32'(ras_empty), 32'h1);
    // 3: stall holds
    cyc(0, 1, 3'b110, 16'h1234, 0);
    cyc(0, 1, 3'b110, 16'h1234, 0);
    chk("t3_hold", 32'(pc_out), 32'h0011);
    cyc(0, 0, 3'b110, 16'h1234, 0);
    chk("t3_go", 32'(pc_out), 32'h1234);
    // 4: return on empty
    cyc(0, 0, 3'b101, 0, 16'h0ABC);
    chk("t4_pc", 32'(pc_out), 32'h0ABC);
    chk("t4_err", 32'(ras_err), 32'h1);
    chk("t4_cnt", 32'(ras_count), 32'h0);
    cyc(0, 0, 3'b000, 0, 0);
    chk("t4_errclr", 32'(ras_err), 32'h0);
    // 5: overflow then unwind
    cyc(0, 0, 3'b110, 16'h0000, 0);
    for (int k = 1; k <= 5; k++)
      cyc(0, 0, 3'b100, 16'(k * 256), 0);
`ifdef PC_RAS_WRAP_EN
    chk("t5_err", 32'(ras_err), 32'h0);
    cyc(0, 0, 3'b101, 0, 16'h0777);
    chk("t5_r1", 32'(pc_out), 32'h0401);
    cyc(0, 0, 3'b101, 0, 16'h0777);
    chk("t5_r2", 32'(pc_out), 32'h0301);
    cyc(0, 0, 3'b101, 0, 16'h0777);
    chk("t5_r3", 32'(pc_out), 32'h0201);
    cyc(0, 0, 3'b101, 0, 16'h0777);
    chk("t5_r4", 32'(pc_out), 32'h0101);
`else
    chk("t5_err", 32'(ras_err), 32'h1);
    cyc(0, 0, 3'b101, 0, 16'h0777);
    chk("t5_r1", 32'(pc_out), 32'h0301);
    cyc(0, 0, 3'b101, 0, 16'h0777);
    chk("t5_r2", 32'(pc_out), 32'h0201);
    cyc(0, 0, 3'b101, 0, 16'h0777);
    chk("t5_r3", 32'(pc_out), 32'h0101);
    cyc(0, 0, 3'b101, 0, 16'h0777);
    chk("t5_r4", 32'(pc_out), 32'h0001);
`endif
    cyc(0, 0, 3'b101, 0, 16'h0777);
    chk("t5_r5", 32'(pc_out), 32'h0777);
    chk("t5_r5err", 32'(ras_err), 32'h1);
    // 6: wrap and reset during call
    cyc(0, 0, 3'b110, 16'hFFFF, 0);
    cyc(0, 0, 3'b000, 0, 0);
    chk("t6_wrap", 32'(pc_out), 32'h0000);
    cyc(0, 0, 3'b110, 16'hFFFF, 0);
    cyc(0, 0, 3'b100, 16'h0005, 0);
    cyc(0, 0, 3'b101, 0, 0);
    chk("t6_pushwrap", 32'(pc_out), 32'h0000);
    cyc(0, 0, 3'b100, 16'h0040, 0);
    cyc(1, 0, 3'b100, 16'h0080, 0);
    chk("t6_rst_pc", 32'(pc_out), 32'h0);
    chk("t6_rst_cnt", 32'(ras_count), 32'h0);
    // random phase
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 3) == 0,
          3'($urandom_range(0, 7)),
          16'($urandom), 16'($urandom));
    end
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
